// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy
// scoreboard. Decode reads operands and busy flags combinationally, issue marks
// destinations busy, and the write ports retire results and clear busy.
// An optional bypass makes a same-cycle write visible on the read ports.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
   output logic [NUM_RD-1:0]          o_rd_busy,
   input  logic [NUM_WR-1:0]          i_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   i_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   i_wr_data,
   input  logic                       i_iss_en,
   input  logic [ADDR_W-1:0]          i_iss_addr,
   output logic [NUM_REGS-1:0]        o_busy_vec
);

   // Address space fully populated means no read can fall outside the file.
   localparam bit FULL_RANGE = (NUM_REGS == (1 << ADDR_W));
   localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

   logic [ADDR_W-1:0]   wr_addr  [NUM_WR];
   logic [DATA_W-1:0]   wr_data  [NUM_WR];
   logic [DATA_W-1:0]   reg_data [NUM_REGS];
   logic [NUM_REGS-1:0] reg_busy;

   genvar gi;

   // Split the flattened write buses into per-port fields
   generate
      for (gi = 0; gi < NUM_WR; gi++) begin : gen_wr_unpack
         assign wr_addr[gi] = i_wr_addr[gi*ADDR_W +: ADDR_W];
         assign wr_data[gi] = i_wr_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // One storage slot per architectural register
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
         if ((ZERO_REG != 0) && (gi == 0)) begin : gen_zero
            // Hardwired zero: writes and issues to it simply have nowhere to land
            assign reg_data[gi] = '0;
            assign reg_busy[gi] = 1'b0;
         end else begin : gen_flop
            localparam logic [ADDR_W-1:0] REG_ADDR = ADDR_W'(gi);

            logic              wr_hit;
            logic              iss_hit;
            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] data_next;
            logic              busy_reg;
            logic              busy_next;

            assign iss_hit = i_iss_en && (i_iss_addr == REG_ADDR);

            // Merge every write port aimed here; higher ports are applied later and win
            always_comb begin
               wr_hit    = 1'b0;
               data_next = data_reg;
               for (int k = 0; k < NUM_WR; k++) begin
                  if (i_wr_en[k] && (wr_addr[k] == REG_ADDR)) begin
                     wr_hit    = 1'b1;
                     data_next = wr_data[k];
                  end
               end
            end

            // A new producer outranks a retiring one; otherwise retirement clears busy
            always_comb begin
               busy_next = busy_reg;
               if (iss_hit) begin
                  busy_next = 1'b1;
               end else if (wr_hit) begin
                  busy_next = 1'b0;
               end
            end

            // Data and busy flops, wiped immediately by reset
            always_ff @(posedge i_clk or posedge i_rst) begin
               if (i_rst) begin
                  data_reg <= '0;
                  busy_reg <= 1'b0;
               end else begin
                  data_reg <= data_next;
                  busy_reg <= busy_next;
               end
            end

            assign reg_data[gi] = data_reg;
            assign reg_busy[gi] = busy_reg;
         end
      end
   endgenerate

   // Read ports: stored value, optionally overridden by a same-cycle write
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : gen_rd
         logic [ADDR_W-1:0] rd_addr;
         logic              in_range;
         logic              is_zero;
         logic [DATA_W-1:0] rd_data;
         logic              rd_busy;

         assign rd_addr = i_rd_addr[gi*ADDR_W +: ADDR_W];
         assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

         if (FULL_RANGE) begin : gen_full
            assign in_range = 1'b1;
         end else begin : gen_part
            assign in_range = ({1'b0, rd_addr} < REG_LIMIT);
         end

         // Reset, register 0 and unmapped addresses all read as idle zero
         always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (!i_rst && in_range && !is_zero) begin
               rd_data = reg_data[rd_addr];
               rd_busy = reg_busy[rd_addr];
               if (BYPASS != 0) begin
                  for (int k = 0; k < NUM_WR; k++) begin
                     if (i_wr_en[k] && (wr_addr[k] == rd_addr)) begin
                        rd_data = wr_data[k];
                        rd_busy = 1'b0;
                     end
                  end
               end
            end
         end

         assign o_rd_data[gi*DATA_W +: DATA_W] = rd_data;
         assign o_rd_busy[gi]                  = rd_busy;
      end
   endgenerate

   assign o_busy_vec = reg_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomised stimulus against a bypassing and a
// non-bypassing build of regfile_mp driven in parallel. Expected values come
// from a small behavioural model plus hand-written constants, queued when the
// stimulus is applied and compared once the outputs have settled.
module tb_regfile_mp;
   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;

   typedef struct {
      string       tag;
      int          dut;   // 0 = bypass build, 1 = no-bypass build
      int          kind;  // 0 = rd_data, 1 = rd_busy, 2 = busy_vec
      int          idx;
      logic [31:0] exp;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rd_addr;
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic [NRD*DW-1:0] rd_data_b, rd_data_n;
   logic [NRD-1:0]    rd_busy_b, rd_busy_n;
   logic [NR-1:0]     busy_vec_b, busy_vec_n;

   logic [DW-1:0]     m_mem [NR];
   logic [NR-1:0]     m_busy;
   exp_t              sb[$];
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
      .o_rd_busy(rd_busy_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_iss_en(iss_en), .i_iss_addr(iss_addr),
      .o_busy_vec(busy_vec_b)
   );

   regfile_mp #(.BYPASS(0)) dut_n (
      .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n),
      .o_rd_busy(rd_busy_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_iss_en(iss_en), .i_iss_addr(iss_addr),
      .o_busy_vec(busy_vec_n)
   );

   task automatic push(input string tag, input int dut, input int kind,
                       input int idx, input logic [31:0] e);
      exp_t x;
      x.tag  = tag;
      x.dut  = dut;
      x.kind = kind;
      x.idx  = idx;
      x.exp  = e;
      sb.push_back(x);
   endtask

   task automatic expect_rd(input string tag, input int dut, input int port,
                            input logic [31:0] d, input logic b);
      push({tag, "_data"}, dut, 0, port, d);
      push({tag, "_busy"}, dut, 1, port, {31'b0, b});
   endtask

   task automatic expect_vec(input string tag, input int dut, input logic [31:0] v);
      push({tag, "_vec"}, dut, 2, 0, v);
   endtask

   function automatic logic [31:0] observe(input int dut, input int kind, input int idx);
      logic [31:0] v;
      v = '0;
      if (dut == 0) begin
         if (kind == 0)      v = rd_data_b[idx*DW +: DW];
         else if (kind == 1) v = {31'b0, rd_busy_b[idx]};
         else                v = busy_vec_b;
      end else begin
         if (kind == 0)      v = rd_data_n[idx*DW +: DW];
         else if (kind == 1) v = {31'b0, rd_busy_n[idx]};
         else                v = busy_vec_n;
      end
      return v;
   endfunction

   // What a read port should show given the model state and current inputs.
   task automatic model_read(input int dut, input int port,
                             output logic [31:0] d, output logic b);
      logic [AW-1:0] a;
      a = rd_addr[port*AW +: AW];
      d = '0;
      b = 1'b0;
      if (!rst && (a != 0)) begin
         d = m_mem[a];
         b = m_busy[a];
         if (dut == 0) begin
            for (int k = 0; k < NWR; k++) begin
               if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) begin
                  d = wr_data[k*DW +: DW];
                  b = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic drain();
      exp_t        x;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         x   = sb.pop_front();
         obs = observe(x.dut, x.kind, x.idx);
         checks++;
         assert (obs === x.exp) else begin
            errors++;
            $error("FAIL %s dut%0d idx%0d: observed %h expected %h",
                   x.tag, x.dut, x.idx, obs, x.exp);
         end
      end
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic step(input string tag);
      logic [31:0] d;
      logic        b;
      if (rst) begin
         for (int r = 0; r < NR; r++) m_mem[r] = '0;
         m_busy = '0;
      end
      for (int dut = 0; dut < 2; dut++) begin
         for (int p = 0; p < NRD; p++) begin
            model_read(dut, p, d, b);
            expect_rd({tag, "_model"}, dut, p, d, b);
         end
         expect_vec({tag, "_model"}, dut, m_busy);
      end
      #1;
      drain();
      $display("txn %-12s rst=%0b rd=%h wr_en=%b wr_addr=%h wr_data=%h iss=%0b:%0d",
               tag, rst, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr);
      if (!rst) begin
         for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != 0)) begin
               m_mem[wr_addr[k*AW +: AW]]  = wr_data[k*DW +: DW];
               m_busy[wr_addr[k*AW +: AW]] = 1'b0;
            end
         end
         if (iss_en && (iss_addr != 0)) m_busy[iss_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a,
                         input logic [31:0] d);
      wr_en[p]             = en;
      wr_addr[p*AW +: AW]  = a;
      wr_data[p*DW +: DW]  = d;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic idle();
      wr_en  = '0;
      iss_en = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
      for (int r = 0; r < NR; r++) m_mem[r] = '0;
      m_busy = '0;
      @(negedge clk);

      // Reset held with a write and an issue presented: nothing visible, nothing kept
      set_wr(0, 1'b1, 5'd1, 32'hDEAD_BEEF);
      iss_en = 1'b1; iss_addr = 5'd2;
      set_rd(5'd1, 5'd2);
      for (int dut = 0; dut < 2; dut++) begin
         expect_rd("rst_hold", dut, 0, 32'h0, 1'b0);
         expect_vec("rst_hold", dut, 32'h0);
      end
      step("rst_hold");

      rst = 1'b0;
      idle();
      set_rd(5'd1, 5'd2);
      for (int dut = 0; dut < 2; dut++) begin
         expect_rd("rst_lost", dut, 0, 32'h0, 1'b0);
         expect_vec("rst_lost", dut, 32'h0);
      end
      step("rst_lost");

      // Fill r1..r31
      for (int r = 1; r < NR; r++) begin
         idle();
         set_wr(0, 1'b1, AW'(r), 32'hA5A5_0000 + 32'(r));
         set_rd(AW'(r), AW'(r - 1));
         expect_rd("fill_byp", 0, 0, 32'hA5A5_0000 + 32'(r), 1'b0);
         expect_rd("fill_old", 1, 0, 32'h0, 1'b0);
         step("fill");
      end

      // Issue r7, then reset mid-stream
      idle();
      iss_en = 1'b1; iss_addr = 5'd7;
      set_rd(5'd7, 5'd8);
      expect_rd("iss7_same", 0, 0, 32'hA5A5_0007, 1'b0);
      step("iss7");

      idle();
      set_rd(5'd7, 5'd8);
      expect_rd("iss7_next", 0, 0, 32'hA5A5_0007, 1'b1);
      expect_vec("iss7_next", 0, 32'h0000_0080);
      expect_vec("iss7_next", 1, 32'h0000_0080);
      step("iss7_next");

      rst = 1'b1;
      set_rd(5'd7, 5'd31);
      for (int dut = 0; dut < 2; dut++) begin
         expect_rd("rst_mid0", dut, 0, 32'h0, 1'b0);
         expect_rd("rst_mid1", dut, 1, 32'h0, 1'b0);
         expect_vec("rst_mid", dut, 32'h0);
      end
      step("rst_mid");

      rst = 1'b0;
      set_rd(5'd7, 5'd31);
      for (int dut = 0; dut < 2; dut++) begin
         expect_rd("rst_after", dut, 1, 32'h0, 1'b0);
         expect_vec("rst_after", dut, 32'h0);
      end
      step("rst_after");

      // Write conflict on r5: port 1 wins
      idle();
      set_wr(0, 1'b1, 5'd5, 32'h0000_1111);
      set_wr(1, 1'b1, 5'd5, 32'h0000_2222);
      set_rd(5'd5, 5'd5);
      expect_rd("wconf_byp", 0, 0, 32'h0000_2222, 1'b0);
      expect_rd("wconf_old", 1, 0, 32'h0, 1'b0);
      step("wconf");

      idle();
      set_rd(5'd5, 5'd0);
      expect_rd("wconf_next", 0, 0, 32'h0000_2222, 1'b0);
      expect_rd("wconf_next", 1, 0, 32'h0000_2222, 1'b0);
      step("wconf_next");

      // Register 0: write and issue both ignored
      idle();
      set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      iss_en = 1'b1; iss_addr = 5'd0;
      set_rd(5'd0, 5'd0);
      for (int dut = 0; dut < 2; dut++) begin
         expect_rd("zero_p0", dut, 0, 32'h0, 1'b0);
         expect_rd("zero_p1", dut, 1, 32'h0, 1'b0);
      end
      step("zero");

      idle();
      set_rd(5'd0, 5'd0);
      for (int dut = 0; dut < 2; dut++) begin
         expect_rd("zero_next", dut, 0, 32'h0, 1'b0);
         expect_vec("zero_next", dut, 32'h0);
      end
      step("zero_next");

      // Scoreboard lifecycle on r3
      idle();
      iss_en = 1'b1; iss_addr = 5'd3;
      set_rd(5'd3, 5'd3);
      step("sb_n");

      idle();
      set_rd(5'd3, 5'd4);
      expect_rd("sb_n1", 0, 0, 32'h0, 1'b1);
      expect_vec("sb_n1", 0, 32'h0000_0008);
      step("sb_n1");

      idle();
      set_rd(5'd3, 5'd3);
      step("sb_n2");
      step("sb_n3");

      set_wr(1, 1'b1, 5'd3, 32'h0000_0042);
      set_rd(5'd3, 5'd3);
      expect_rd("sb_n4_byp", 0, 0, 32'h0000_0042, 1'b0);
      expect_rd("sb_n4_old", 1, 0, 32'h0, 1'b1);
      step("sb_n4");

      idle();
      set_rd(5'd3, 5'd3);
      expect_vec("sb_n5", 0, 32'h0);
      expect_rd("sb_n5", 1, 0, 32'h0000_0042, 1'b0);
      step("sb_n5");

      // Same-cycle issue and write on an already busy r9
      idle();
      iss_en = 1'b1; iss_addr = 5'd9;
      step("r9_iss");

      idle();
      set_wr(0, 1'b1, 5'd9, 32'h0000_0007);
      iss_en = 1'b1; iss_addr = 5'd9;
      set_rd(5'd9, 5'd9);
      expect_rd("r9_both_byp", 0, 0, 32'h0000_0007, 1'b0);
      expect_rd("r9_both_old", 1, 0, 32'h0, 1'b1);
      step("r9_both");

      idle();
      set_rd(5'd9, 5'd9);
      expect_vec("r9_next", 0, 32'h0000_0200);
      expect_rd("r9_next", 0, 0, 32'h0000_0007, 1'b1);
      expect_rd("r9_next", 1, 0, 32'h0000_0007, 1'b1);
      step("r9_next");

      // No-bypass build sees a write one cycle later
      idle();
      set_wr(0, 1'b1, 5'd4, 32'h0000_0055);
      set_rd(5'd4, 5'd4);
      expect_rd("nb_n_old", 1, 0, 32'h0, 1'b0);
      expect_rd("nb_n_byp", 0, 0, 32'h0000_0055, 1'b0);
      step("nb_n");

      idle();
      set_rd(5'd4, 5'd4);
      expect_rd("nb_n1", 1, 0, 32'h0000_0055, 1'b0);
      step("nb_n1");

      // Random traffic against the model, with occasional resets
      for (int i = 0; i < 150; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         wr_en = NWR'($urandom_range(0, 3));
         for (int k = 0; k < NWR; k++) begin
            wr_addr[k*AW +: AW] = AW'($urandom_range(0, NR - 1));
            wr_data[k*DW +: DW] = $urandom;
         end
         iss_en   = ($urandom_range(0, 2) == 0);
         iss_addr = AW'($urandom_range(0, NR - 1));
         set_rd(AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
         step("rand");
      end

      rst = 1'b0;
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with per-register busy scoreboard and optional same-cycle write-to-read bypass. It is the next-generation integer register file for the pipelined core:
- the decode stage reads operands and stalls on busy sources;
- the issue stage marks destination registers busy;
- one or more writeback ports retire results and clear the busy bits.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers; ADDR_W = $clog2(NUM_REGS)
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- BYPASS, 1, 1 = a write in the current cycle is visible combinationally on the read ports; 0 = visible from the next cycle
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- o_rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- o_rd_busy  out  NUM_RD  read port k's register has an outstanding producer
- i_wr_en  in  NUM_WR  write enable per write port
- i_wr_addr  in  NUM_WR*ADDR_W  write addresses
- i_wr_data  in  NUM_WR*DATA_W  write data
- i_iss_en  in  1  mark i_iss_addr busy
- i_iss_addr  in  ADDR_W  destination register of the issuing instruction
- o_busy_vec  out  NUM_REGS  registered busy bits, bit r = register r

## Operation
- **Storage:** NUM_REGS x DATA_W flops plus NUM_REGS busy flops.
- **Writes:**
  - On a rising edge, every port with i_wr_en=1 writes its data to its address.
  - Two or more enabled ports with the same address: the highest port index wins.
  - When ZERO_REG=1, writes to address 0 are discarded.
- **Reads:** combinational from array. Read address >= NUM_REGS returns 0 with busy 0.
- **Bypass (BYPASS=1):** if any enabled write port targets the read address this cycle, o_rd_data returns that port's data (highest index wins) and o_rd_busy is 0.
- **Bypass (BYPASS=0):** the read returns the stored value and the stored busy bit.
- **Register 0 (ZERO_REG=1):** reads of register 0 return 0 with busy 0 regardless of bypass.
- **Busy bit update:**
  - At a rising edge, busy[r] is set if i_iss_en=1 and i_iss_addr=r.
  - Otherwise busy[r] is cleared if any enabled write targets r.
  - Otherwise busy[r] holds.
  - Issue and write to the same register in the same cycle leave busy=1, because the new producer supersedes the retiring one.
  - i_iss_en to register 0 with ZERO_REG=1 is ignored.
- **In-flight producers:** one busy bit per register, so at most one producer per register is in flight. The issue stage enforces this by stalling on WAW. A write to a register whose busy bit is already 0 updates the data and leaves busy 0.
- **Issue visibility:** a same-cycle issue never affects o_rd_busy in that cycle. The reader is older than the issuing instruction.

## Timing
- **Reset:**
  - i_rst=1 asynchronously clears all registers and busy bits.
  - While reset is asserted: o_rd_data = 0, o_rd_busy = 0, o_busy_vec = 0.
  - Writes and issues presented during reset are lost.
  - Reset mid-operation discards all outstanding busy state.
- **Write latency:** 1 cycle to the array. With BYPASS=1, data is visible on read ports in the write cycle (0 cycles).
- **Issue latency:** busy is visible on o_busy_vec and o_rd_busy one cycle after i_iss_en.
- **Combinational paths:**
  - o_rd_data and o_rd_busy depend on i_rd_addr, the array and busy state, and, when BYPASS=1, on i_wr_*.
  - o_busy_vec is a pure flop output.
- **Handshake:** there is no handshake. Every enabled write and issue is accepted on every edge outside reset.

## Test plan
- **Reset:** assert i_rst mid-stream after filling r1..r31 with 0xA5A5_0000+r and issuing r7. Require all reads = 0 and o_busy_vec = 0 immediately, before any clock edge.
- **Write conflict:** ports 0 and 1 both write r5, with 0x1111 and 0x2222. Require r5 = 0x2222 next cycle; with BYPASS=1, same-cycle read of r5 also = 0x2222.
- **Zero register:** write r0 = 0xFFFF_FFFF and issue r0. Require read r0 = 0 and busy 0 on every port, and o_busy_vec[0] = 0.
- **Scoreboard:** issue r3 at cycle n. Require o_busy_vec[3]=1 at n+1; read r3 at n+1 gives busy=1. Write r3 = 0x42 at n+4: with BYPASS=1, read at n+4 gives 0x42 and busy 0; o_busy_vec[3]=0 at n+5.
- **Same-cycle issue and write:** busy r9 set; in one cycle write r9 = 0x7 and issue r9. Require o_busy_vec[9]=1 next cycle and r9 data = 0x7.
- **BYPASS=0 build:** write r4 = 0x55 at cycle n. Require a read at n to return the old value and a read at n+1 to return 0x55.
